// File: rtl/reg_scan_reader.sv
// reg_scan_reader: walks storage addresses 0..NREG-1 over a read port and
// streams each (address, word) pair to a debug sink on a valid/ready handshake.
// Optional feature macro: SCAN_LOOP_EN (continuous rescan until stop is requested).
module reg_scan_reader #(
  parameter int unsigned NREG = 32,
  parameter int unsigned AW   = 5,
  parameter int unsigned DW   = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          CE,
  input  logic          start,
  input  logic          stop,
  output logic [AW-1:0] rd_addr,
  input  logic [DW-1:0] rd_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [AW-1:0] out_addr,
  output logic [DW-1:0] out_data,
  output logic          busy,
  output logic          done
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(NREG - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    SEND = 2'd2
  } state_t;

  state_t        state, state_d;
  logic [AW-1:0] rd_addr_d;
  logic          out_valid_d;
  logic [AW-1:0] out_addr_d;
  logic [DW-1:0] out_data_d;
  logic          busy_d;
  logic          done_d;
  logic          xfer;

  assign xfer = out_valid && out_ready;

`ifdef SCAN_LOOP_EN
  logic stop_req, stop_req_d;

  // Stop request flag: set by stop during a scan, cleared when the scan ends.
  always_ff @(posedge clk) begin
    if (rst) begin
      stop_req <= 1'b0;
    end else begin
      stop_req <= stop_req_d;
    end
  end
`else
  // Single-pass build: stop has no effect.
  logic unused_stop;
  assign unused_stop = stop;
`endif

  // State and output registers; CE gating is resolved in the next-state logic.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rd_addr   <= '0;
      out_valid <= 1'b0;
      out_addr  <= '0;
      out_data  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_d;
      rd_addr   <= rd_addr_d;
      out_valid <= out_valid_d;
      out_addr  <= out_addr_d;
      out_data  <= out_data_d;
      busy      <= busy_d;
      done      <= done_d;
    end
  end

  // Next-state and next-output logic; CE=0 holds everything as-is.
  always_comb begin
    state_d     = state;
    rd_addr_d   = rd_addr;
    out_valid_d = out_valid;
    out_addr_d  = out_addr;
    out_data_d  = out_data;
    busy_d      = busy;
    done_d      = done;
`ifdef SCAN_LOOP_EN
    stop_req_d  = stop_req;
`endif

    if (CE) begin
      done_d = 1'b0;
`ifdef SCAN_LOOP_EN
      if (state != IDLE && stop) begin
        stop_req_d = 1'b1;
      end
`endif
      case (state)
        IDLE: begin
          if (start) begin
            state_d   = READ;
            busy_d    = 1'b1;
            rd_addr_d = '0;
          end
        end

        READ: begin
          out_data_d  = rd_data;
          out_addr_d  = rd_addr;
          out_valid_d = 1'b1;
          state_d     = SEND;
        end

        SEND: begin
          if (xfer) begin
            out_valid_d = 1'b0;
            if (rd_addr < LAST_ADDR) begin
              rd_addr_d = rd_addr + AW'(1);
              state_d   = READ;
            end else begin
              rd_addr_d = '0;
              done_d    = 1'b1;
`ifdef SCAN_LOOP_EN
              if (stop_req || stop) begin
                busy_d     = 1'b0;
                stop_req_d = 1'b0;
                state_d    = IDLE;
              end else begin
                state_d    = READ;
              end
`else
              busy_d  = 1'b0;
              state_d = IDLE;
`endif
            end
          end
        end

        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reg_scan_reader.sv
// Scoreboard bench for reg_scan_reader with NREG=4 and storage word i = A000_000i.
module tb_reg_scan_reader;

  localparam int unsigned NREG = 4;
  localparam int unsigned AW   = 5;
  localparam int unsigned DW   = 32;
  localparam int          NW   = 4;

  logic          clk = 1'b0;
  logic          rst, CE, start, stop, out_ready;
  logic [AW-1:0] rd_addr, out_addr;
  logic [DW-1:0] rd_data, out_data;
  logic          out_valid, busy, done;

  logic [AW+DW-1:0] exp_q[$];
  logic [AW+DW-1:0] got, exp_w;
  int vectors = 0;
  int miscompares = 0;

  reg_scan_reader #(.NREG(NREG), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst), .CE(CE), .start(start), .stop(stop),
    .rd_addr(rd_addr), .rd_data(rd_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_addr(out_addr), .out_data(out_data),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Register-file storage: returns the word for rd_addr within the READ cycle.
  assign rd_data = (rd_addr < AW'(NREG)) ? (32'hA000_0000 | DW'(rd_addr)) : 32'hDEAD_BEEF;

  function automatic logic [AW+DW-1:0] word(input int i);
    return {AW'(i), 32'hA000_0000 + DW'(i)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_pass();
    for (int i = 0; i < NW; i++) exp_q.push_back(word(i));
  endtask

  task automatic test_reset();
    rst = 1'b1; CE = 1'b1; start = 1'b0; stop = 1'b0; out_ready = 1'b0;
    tick(); tick();
    vectors++;
    if ({out_valid, busy, done, rd_addr, out_addr, out_data} !== '0) begin
      miscompares++;
      $display("FAIL reset_state: got v=%b b=%b d=%b ra=%0d oa=%0d od=%h, need all zero",
               out_valid, busy, done, rd_addr, out_addr, out_data);
    end
    rst = 1'b0;
    tick();
    vectors++;
    if ({busy, out_valid} !== 2'b00) begin
      miscompares++;
      $display("FAIL idle_after_reset: got busy=%b valid=%b, need 0 0", busy, out_valid);
    end
  endtask

  task automatic test_single_pass();
    int n = 0;
    int last = -1;
    push_pass();
    out_ready = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    vectors++;
    if ({busy, out_valid} !== 2'b10) begin
      miscompares++;
      $display("FAIL start_edge1: got busy=%b valid=%b, need 1 0", busy, out_valid);
    end
    tick();
    vectors++;
    if (out_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL first_valid_latency: got valid=%b after 2 edges, need 1", out_valid);
    end
    for (int c = 0; c < 40 && n < NW; c++) begin
      if (out_valid && out_ready && CE) begin
        got = {out_addr, out_data};
        if (exp_q.size() != 0) exp_w = exp_q.pop_front(); else exp_w = '1;
        vectors++;
        if (got !== exp_w) begin
          miscompares++;
          $display("FAIL pass_word: got %h, need %h", got, exp_w);
        end
        if (n > 0) begin
          vectors++;
          if (c - last !== 2) begin
            miscompares++;
            $display("FAIL word_slot: got spacing %0d cycles, need 2", c - last);
          end
        end
        last = c;
        n++;
      end
      tick();
    end
    vectors++;
    if (n !== NW) begin
      miscompares++;
      $display("FAIL pass_count: got %0d words, need %0d", n, NW);
    end
    vectors++;
    if ({done, busy, out_valid, rd_addr} !== {1'b1, 1'b0, 1'b0, AW'(0)}) begin
      miscompares++;
      $display("FAIL done_pulse: got d=%b b=%b v=%b ra=%0d, need 1 0 0 0", done, busy, out_valid, rd_addr);
    end
    tick();
    vectors++;
    if (done !== 1'b0) begin
      miscompares++;
      $display("FAIL done_width: got done=%b one cycle later, need 0", done);
    end
  endtask

  task automatic test_backpressure();
    int n = 0;
    bit held = 1'b0;
    push_pass();
    out_ready = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 60 && n < NW; c++) begin
      if (out_valid && !held && out_addr == AW'(2)) begin
        held = 1'b1;
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
          tick();
          vectors++;
          if ({out_valid, out_addr, out_data} !== {1'b1, AW'(2), 32'hA000_0002}) begin
            miscompares++;
            $display("FAIL bp_hold: got v=%b a=%0d d=%h, need 1 2 a0000002", out_valid, out_addr, out_data);
          end
        end
        out_ready = 1'b1;
      end
      if (out_valid && out_ready && CE) begin
        got = {out_addr, out_data};
        if (exp_q.size() != 0) exp_w = exp_q.pop_front(); else exp_w = '1;
        vectors++;
        if (got !== exp_w) begin
          miscompares++;
          $display("FAIL bp_word: got %h, need %h", got, exp_w);
        end
        n++;
      end
      tick();
    end
    vectors++;
    if ({n == NW, held, done, busy} !== 4'b1110) begin
      miscompares++;
      $display("FAIL bp_end: got words=%0d held=%b done=%b busy=%b, need 4 1 1 0", n, held, done, busy);
    end
    tick();
  endtask

  task automatic test_ce_freeze();
    int n = 0;
    bit held = 1'b0;
    bit chk_resume = 1'b0;
    CE = 1'b0; start = 1'b1; out_ready = 1'b1;
    tick(); tick();
    start = 1'b0; CE = 1'b1;
    tick();
    vectors++;
    if ({busy, out_valid} !== 2'b00) begin
      miscompares++;
      $display("FAIL ce_start_ignored: got busy=%b valid=%b, need 0 0", busy, out_valid);
    end
    push_pass();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 60 && n < NW; c++) begin
      if (chk_resume) begin
        chk_resume = 1'b0;
        vectors++;
        if ({out_valid, rd_addr} !== {1'b0, AW'(2)}) begin
          miscompares++;
          $display("FAIL ce_resume: got v=%b ra=%0d, need 0 2", out_valid, rd_addr);
        end
      end
      if (out_valid && !held && out_addr == AW'(1)) begin
        held = 1'b1;
        CE = 1'b0;
        for (int k = 0; k < 3; k++) begin
          tick();
          vectors++;
          if ({out_valid, out_addr, out_data, busy, rd_addr, done} !==
              {1'b1, AW'(1), 32'hA000_0001, 1'b1, AW'(1), 1'b0}) begin
            miscompares++;
            $display("FAIL ce_freeze: got v=%b a=%0d d=%h b=%b ra=%0d dn=%b, need 1 1 a0000001 1 1 0",
                     out_valid, out_addr, out_data, busy, rd_addr, done);
          end
        end
        CE = 1'b1;
        chk_resume = 1'b1;
      end
      if (out_valid && out_ready && CE) begin
        got = {out_addr, out_data};
        if (exp_q.size() != 0) exp_w = exp_q.pop_front(); else exp_w = '1;
        vectors++;
        if (got !== exp_w) begin
          miscompares++;
          $display("FAIL ce_word: got %h, need %h", got, exp_w);
        end
        n++;
      end
      tick();
    end
    vectors++;
    if ({n == NW, held, done, busy} !== 4'b1110) begin
      miscompares++;
      $display("FAIL ce_end: got words=%0d held=%b done=%b busy=%b, need 4 1 1 0", n, held, done, busy);
    end
    tick();
  endtask

  task automatic test_reset_mid_scan();
    bit found = 1'b0;
    out_ready = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 40 && !found; c++) begin
      if (out_valid && out_addr == AW'(1)) found = 1'b1;
      else tick();
    end
    vectors++;
    if (found !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_reach_addr1: got found=%b, need 1", found);
    end
    out_ready = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    vectors++;
    if ({out_valid, busy, rd_addr, done} !== {1'b0, 1'b0, AW'(0), 1'b0}) begin
      miscompares++;
      $display("FAIL rst_mid_scan: got v=%b b=%b ra=%0d d=%b, need 0 0 0 0", out_valid, busy, rd_addr, done);
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      vectors++;
      if ({done, busy, out_valid} !== 3'b000) begin
        miscompares++;
        $display("FAIL rst_no_done: got d=%b b=%b v=%b, need 0 0 0", done, busy, out_valid);
      end
    end
    exp_q.delete();
    test_single_pass();
  endtask

  task automatic test_start_held();
    int n = 0;
    push_pass();
    out_ready = 1'b1; start = 1'b1;
    for (int c = 0; c < 40 && n < NW; c++) begin
      if (out_valid && out_ready && CE) begin
        got = {out_addr, out_data};
        if (exp_q.size() != 0) exp_w = exp_q.pop_front(); else exp_w = '1;
        vectors++;
        if (got !== exp_w) begin
          miscompares++;
          $display("FAIL held_word1: got %h, need %h", got, exp_w);
        end
        n++;
      end
      tick();
    end
    vectors++;
    if ({n == NW, done, busy} !== 3'b110) begin
      miscompares++;
      $display("FAIL held_pass1_end: got words=%0d done=%b busy=%b, need 4 1 0", n, done, busy);
    end
    tick();
    start = 1'b0;
    vectors++;
    if ({busy, out_valid, done} !== 3'b100) begin
      miscompares++;
      $display("FAIL held_restart: got busy=%b valid=%b done=%b, need 1 0 0", busy, out_valid, done);
    end
    push_pass();
    n = 0;
    for (int c = 0; c < 40 && n < NW; c++) begin
      if (out_valid && out_ready && CE) begin
        got = {out_addr, out_data};
        if (exp_q.size() != 0) exp_w = exp_q.pop_front(); else exp_w = '1;
        vectors++;
        if (got !== exp_w) begin
          miscompares++;
          $display("FAIL held_word2: got %h, need %h", got, exp_w);
        end
        n++;
      end
      tick();
    end
    vectors++;
    if ({n == NW, done, busy} !== 3'b110) begin
      miscompares++;
      $display("FAIL held_pass2_end: got words=%0d done=%b busy=%b, need 4 1 0", n, done, busy);
    end
    tick();
  endtask

`ifdef SCAN_LOOP_EN
  task automatic test_loop();
    int n = 0;
    int dones = 0;
    push_pass(); push_pass(); push_pass();
    out_ready = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 200 && n < 3 * NW; c++) begin
      stop = 1'b0;
      if (done) begin
        dones++;
        vectors++;
        if (busy !== 1'b1) begin
          miscompares++;
          $display("FAIL loop_busy: got busy=%b at done %0d, need 1", busy, dones);
        end
      end
      if (out_valid && out_ready && CE) begin
        if (n == 2 * NW + 1) stop = 1'b1;
        got = {out_addr, out_data};
        if (exp_q.size() != 0) exp_w = exp_q.pop_front(); else exp_w = '1;
        vectors++;
        if (got !== exp_w) begin
          miscompares++;
          $display("FAIL loop_word: got %h, need %h", got, exp_w);
        end
        n++;
      end
      tick();
    end
    stop = 1'b0;
    vectors++;
    if ({n == 3 * NW, dones == 2, done, busy, out_valid} !== 5'b11100) begin
      miscompares++;
      $display("FAIL loop_stop_end: got words=%0d dones=%0d d=%b b=%b v=%b, need 12 2 1 0 0",
               n, dones, done, busy, out_valid);
    end
    tick(); tick();
    vectors++;
    if ({busy, out_valid, done} !== 3'b000) begin
      miscompares++;
      $display("FAIL loop_idle: got b=%b v=%b d=%b, need 0 0 0", busy, out_valid, done);
    end
  endtask
`endif

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_single_pass();
    test_backpressure();
    test_ce_freeze();
    test_reset_mid_scan();
    test_start_held();
`ifdef SCAN_LOOP_EN
    test_loop();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
